phv_rr_scheduler: RTL
=====================

Name: phv_rr_scheduler

Overview:
- Shares the single stage-0 PHV input among N_PORTS parser instances using round-robin arbitration.
- Gates admission with a credit counter sized to the downstream PHV FIFO depth, so PHVs cannot overrun that FIFO. The FIFO's full flag is not used for flow control.
- Sits between the per-port parsers and stage 0. Credits return when the deparser pops the PHV FIFO.
- Tags each forwarded PHV with its source port so the deparser side can pair the PHV with the correct packet FIFO.

Parameters:
- N_PORTS, 4, number of requesting parsers (2..8).
- PHV_WIDTH, 1124, PHV width in bits.
- CREDITS, 32, PHV FIFO depth, which is the maximum number of PHVs in flight from grant to FIFO pop.
- SRC_W, $clog2(N_PORTS), width of the source-port tag.
- CNT_W, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clk, in, 1, clock.
- aresetn, in, 1, synchronous active-low reset.
- s_phv_data, in, N_PORTS*PHV_WIDTH, per-port PHV; port i occupies bits [i*PHV_WIDTH +: PHV_WIDTH].
- s_phv_valid, in, N_PORTS, per-port PHV valid. Held until accepted.
- s_phv_ready, out, N_PORTS, per-port accept. One-hot or zero.
- m_phv_data, out, PHV_WIDTH, PHV to stage 0 (registered).
- m_phv_valid, out, 1, single-cycle strobe to stage 0 (registered).
- m_phv_src, out, SRC_W, source port of m_phv_data.
- credit_return, in, 1, one pulse per PHV FIFO pop (phv_fifo_rd_en).
- sched_en, in, 1, admission enable.
- credit_avail, out, CNT_W, current credit count.
- err_credit_ovf, out, 1, sticky flag: credit returned while the counter was already at CREDITS.

Behaviour:
- Reset values: m_phv_valid=0, m_phv_data=0, m_phv_src=0, s_phv_ready=0, credit_avail=CREDITS, err_credit_ovf=0, rr pointer=0.
- Reset is synchronous and active-low on aresetn with clock clk. Reset mid-operation drops any registered output and restores credits to CREDITS. The environment must also flush the PHV FIFO.
- Grant logic is combinational:
  - eligible = sched_en & (credit_avail != 0).
  - Winner = first i with s_phv_valid[i] set, searching ptr, ptr+1, …, ptr+N_PORTS-1, modulo N_PORTS.
  - s_phv_ready[winner] = eligible. All other ready bits are 0.
  - s_phv_ready depends only on valid, pointer, credits and sched_en, never on m_* signals.
- Transfer occurs when s_phv_valid[i] & s_phv_ready[i]. In the next cycle:
  - m_phv_valid=1, m_phv_data = port i's PHV, m_phv_src=i;
  - ptr = (i+1) mod N_PORTS.
- With no transfer: m_phv_valid=0, ptr holds, and m_phv_data/m_phv_src hold their last value.
- Latency is 1 cycle from accept to m_phv_valid. Throughput is at most one PHV per cycle across all ports. Stage 0 applies no backpressure.
- Credit counter per cycle:
  - Grant without return: count - 1.
  - Return without grant: count + 1.
  - Grant and return in the same cycle: count unchanged.
- Credit boundaries:
  - Count 0: no grant that cycle, even if a return arrives the same cycle. The returned credit is usable the next cycle.
  - Return at count == CREDITS with no grant: count stays at CREDITS and err_credit_ovf is set. The flag clears only on reset.
- Fairness: with all ports continuously valid and credits available, grants rotate 0,1,…,N_PORTS-1. No port waits more than N_PORTS-1 grants.
- sched_en deasserted: no new grants; the already-registered output still issues; credit returns continue to be counted. Reasserting resumes from the current ptr.
- Ports with valid low are skipped without consuming a turn.

Decomposition:
- Shared package rmt_pkg holds:
  - PHV_WIDTH (1124) and the PHV field-layout constants already used by parser, stage and deparser;
  - the default N_PORTS;
  - the phv_src_t typedef.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr, en;
  - outputs: one-hot gnt, encoded gnt_idx;
  - purely combinational priority rotation, reusable for packet-FIFO read arbitration.
- The top level holds the pointer, credit counter, output registers and error flag.

Test Plan:
- Reset then idle: credit_avail=32, all s_phv_ready=0, m_phv_valid=0, err_credit_ovf=0.
- Ports 0–3 continuously valid with PHVs 0xA0..0xA3 and no credit return → grants in order 0,1,2,3,0,…; m_phv_src follows; m_phv_valid appears 1 cycle after each accept. After 32 grants credit_avail=0 and all ready bits stay 0.
- At credit_avail=0, one credit_return pulse → the next cycle exactly one grant goes to the port at ptr, and credit_avail returns to 0.
- Grant and credit_return in the same cycle at credit_avail=5 → credit_avail stays 5.
- Only ports 1 and 3 valid, ptr=2 → port 3 granted first, then port 1; ports 0 and 2 never ready.
- credit_return pulsed at credit_avail=32 → credit_avail stays 32 and err_credit_ovf=1. It stays 1 through traffic until aresetn=0 for one cycle, which clears it and restores credit_avail=32 mid-burst.

Source files
------------

// File: rtl/rmt_pkg.sv
// Shared RMT pipeline definitions: PHV geometry, field layout
// and the default parser port count.
package rmt_pkg;

    localparam int PHV_WIDTH    = 1124;
    localparam int PHV_B_CNT    = 64;
    localparam int PHV_H_CNT    = 32;
    localparam int PHV_META_W   = 100;
    localparam int PHV_B_OFF    = 0;
    localparam int PHV_H_OFF    = PHV_B_OFF + PHV_B_CNT * 8;
    localparam int PHV_META_OFF = PHV_H_OFF + PHV_H_CNT * 16;

    localparam int N_PORTS_DEF  = 4;

    typedef logic [$clog2(N_PORTS_DEF)-1:0] phv_src_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr
// and wraps; gnt is one-hot (or zero when en is low).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = W'(j);
            end
        end
        if (found && en) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/phv_rr_scheduler.sv
// Round-robin admission of per-port parser PHVs into stage 0,
// credit-gated against the downstream PHV FIFO depth.
module phv_rr_scheduler #(
    parameter int N_PORTS   = rmt_pkg::N_PORTS_DEF,
    parameter int PHV_WIDTH = rmt_pkg::PHV_WIDTH,
    parameter int CREDITS   = 32,
    parameter int SRC_W     = $clog2(N_PORTS),
    parameter int CNT_W     = $clog2(CREDITS + 1)
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [N_PORTS*PHV_WIDTH-1:0] s_phv_data,
    input  logic [N_PORTS-1:0]           s_phv_valid,
    output logic [N_PORTS-1:0]           s_phv_ready,
    output logic [PHV_WIDTH-1:0]         m_phv_data,
    output logic                         m_phv_valid,
    output logic [SRC_W-1:0]             m_phv_src,
    input  logic                         credit_return,
    input  logic                         sched_en,
    output logic [CNT_W-1:0]             credit_avail,
    output logic                         err_credit_ovf
);

    import rmt_pkg::*;

    logic [SRC_W-1:0]     ptr_q, ptr_d, win_idx;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [N_PORTS-1:0]   gnt;
    logic [CNT_W-1:0]     credit_q, credit_d;
    logic [PHV_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, err_q, err_d;
    logic                 eligible, xfer;

    // Ready stays low while reset is held so no parser sees an accept.
    assign eligible = aresetn & sched_en & (credit_q != '0);

    rr_arbiter #(
        .N (N_PORTS),
        .W (SRC_W)
    ) u_arb (
        .req     (s_phv_valid),
        .ptr     (ptr_q),
        .en      (eligible),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign s_phv_ready = gnt;
    assign xfer        = |(s_phv_valid & gnt);

    always_comb begin
        ptr_d    = ptr_q;
        src_d    = src_q;
        data_d   = data_q;
        credit_d = credit_q;
        err_d    = err_q;
        if (xfer) begin
            src_d  = win_idx;
            data_d = s_phv_data[int'(win_idx)*PHV_WIDTH +: PHV_WIDTH];
            ptr_d  = (win_idx == SRC_W'(N_PORTS - 1)) ?
                     '0 : win_idx + SRC_W'(1);
        end
        unique case ({xfer, credit_return})
            2'b10: credit_d = credit_q - CNT_W'(1);
            2'b01: begin
                if (credit_q == CNT_W'(CREDITS)) err_d = 1'b1;
                else credit_d = credit_q + CNT_W'(1);
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ptr_q    <= '0;
            src_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= CNT_W'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            src_q    <= src_d;
            data_q   <= data_d;
            valid_q  <= xfer;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign m_phv_data     = data_q;
    assign m_phv_valid    = valid_q;
    assign m_phv_src      = src_q;
    assign credit_avail   = credit_q;
    assign err_credit_ovf = err_q;

endmodule
